// File: rtl/jedro_1_top_if.sv
// rtl/jedro_1_top_if.sv - instruction and data memory port interfaces for jedro_1_top
interface ram_read_io #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] rdata;
  modport MASTER (output addr, input rdata);
  modport SLAVE  (input addr, output rdata);
endinterface

interface ram_rw_io;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic [31:0] rdata;
  modport MASTER (output addr, output wdata, output we, input rdata);
  modport SLAVE  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/jedro_1_top.sv
// rtl/jedro_1_top.sv - non-pipelined RV32I subset core (FETCH/EXEC/MEM) with mscratch CSR
module jedro_1_regfile (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  input  logic        i_we,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_rd_data
);
  logic [31:0] regfile [0:31];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (i_we && (i_rd_addr != 5'd0)) begin
      regfile[i_rd_addr] <= i_rd_data;
    end
  end

  assign o_rs1_data = (i_rs1_addr == 5'd0) ? '0 : regfile[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == 5'd0) ? '0 : regfile[i_rs2_addr];
endmodule

module jedro_1_csr (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata
);
  logic [31:0] csr_mscratch_r;
  logic [31:0] csr_mscratch_n;

  // Register reloads every cycle; the next value only differs while a CSR write executes
  assign csr_mscratch_n = i_we ? i_wdata : csr_mscratch_r;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) csr_mscratch_r <= '0;
    else         csr_mscratch_r <= csr_mscratch_n;
  end

  assign o_rdata = csr_mscratch_r;
endmodule

module jedro_1_top #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  ram_read_io.MASTER instr_mem_if,
  ram_rw_io.MASTER   data_mem_if
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM} state_t;

  state_t                r_state, w_state_n;
  logic [31:0]           r_pc, w_pc_n;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [31:0]           w_instr;
  logic [6:0]            w_opcode;
  logic [4:0]            w_rd, w_rs1, w_rs2;
  logic [2:0]            w_f3;
  logic [31:0]           w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0]           w_rs1_val, w_rs2_val;
  logic [31:0]           w_alu_b, w_alu_res;
  logic [4:0]            w_shamt;
  logic                  w_taken;
  logic                  w_rd_we;
  logic [31:0]           w_rd_data;
  logic                  w_is_csr, w_csr_we;
  logic [31:0]           w_csr_src, w_csr_wdata, w_csr_rdata;
  logic [3:0]            w_dmem_we;

  // rdata is only valid during EXEC; MEM works from the latched copy
  assign w_instr  = (r_state == S_EXEC) ? instr_mem_if.rdata : r_instr;
  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign w_f3     = w_instr[14:12];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];
  assign w_imm_i  = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s  = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b  = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_u  = {w_instr[31:12], 12'b0};
  assign w_imm_j  = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

  assign w_alu_b = (w_opcode == OP_REG) ? w_rs2_val : w_imm_i;
  assign w_shamt = w_alu_b[4:0];

  always_comb begin
    w_alu_res = '0;
    case (w_f3)
      3'b000: w_alu_res = (w_opcode == OP_REG && w_instr[30]) ? w_rs1_val - w_alu_b : w_rs1_val + w_alu_b;
      3'b001: w_alu_res = w_rs1_val << w_shamt;
      3'b010: w_alu_res = {31'b0, $signed(w_rs1_val) < $signed(w_alu_b)};
      3'b011: w_alu_res = {31'b0, w_rs1_val < w_alu_b};
      3'b100: w_alu_res = w_rs1_val ^ w_alu_b;
      3'b101: w_alu_res = w_instr[30] ? 32'($signed(w_rs1_val) >>> w_shamt) : w_rs1_val >> w_shamt;
      3'b110: w_alu_res = w_rs1_val | w_alu_b;
      3'b111: w_alu_res = w_rs1_val & w_alu_b;
      default: w_alu_res = '0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'b000: w_taken = (w_rs1_val == w_rs2_val);
      3'b001: w_taken = (w_rs1_val != w_rs2_val);
      3'b100: w_taken = ($signed(w_rs1_val) < $signed(w_rs2_val));
      3'b101: w_taken = !($signed(w_rs1_val) < $signed(w_rs2_val));
      3'b110: w_taken = (w_rs1_val < w_rs2_val);
      3'b111: w_taken = !(w_rs1_val < w_rs2_val);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_is_csr  = (w_opcode == OP_SYSTEM) && (w_f3[1:0] != 2'b00) && (w_instr[31:20] == 12'h340);
  assign w_csr_src = w_f3[2] ? {27'b0, w_rs1} : w_rs1_val;

  always_comb begin
    w_state_n   = r_state;
    w_pc_n      = r_pc;
    w_rd_we     = 1'b0;
    w_rd_data   = '0;
    w_csr_we    = 1'b0;
    w_csr_wdata = w_csr_rdata;
    w_dmem_we   = 4'b0000;
    case (r_state)
      S_FETCH: w_state_n = S_EXEC;
      S_EXEC: begin
        w_state_n = S_FETCH;
        w_pc_n    = r_pc + 32'd4;
        case (w_opcode)
          OP_LUI:   begin w_rd_we = 1'b1; w_rd_data = w_imm_u; end
          OP_AUIPC: begin w_rd_we = 1'b1; w_rd_data = r_pc + w_imm_u; end
          OP_JAL: begin
            w_rd_we   = 1'b1;
            w_rd_data = r_pc + 32'd4;
            w_pc_n    = r_pc + w_imm_j;
          end
          OP_JALR: if (w_f3 == 3'b000) begin
            w_rd_we   = 1'b1;
            w_rd_data = r_pc + 32'd4;
            w_pc_n    = (w_rs1_val + w_imm_i) & ~32'd1;
          end
          OP_BRANCH: if (w_taken) w_pc_n = r_pc + w_imm_b;
          OP_IMM, OP_REG: begin w_rd_we = 1'b1; w_rd_data = w_alu_res; end
          OP_LOAD, OP_STORE: if (w_f3 == 3'b010) begin
            w_state_n = S_MEM;
            w_pc_n    = r_pc;
          end
          OP_SYSTEM: if (w_is_csr) begin
            w_rd_we   = 1'b1;
            w_rd_data = w_csr_rdata;
            // Set/clear with a zero rs1 field is a pure read
            case (w_f3[1:0])
              2'b01: begin w_csr_we = 1'b1; w_csr_wdata = w_csr_src; end
              2'b10: begin w_csr_we = (w_rs1 != 5'd0); w_csr_wdata = w_csr_rdata | w_csr_src; end
              2'b11: begin w_csr_we = (w_rs1 != 5'd0); w_csr_wdata = w_csr_rdata & ~w_csr_src; end
              default: w_csr_we = 1'b0;
            endcase
          end
          default: w_state_n = S_FETCH;
        endcase
      end
      S_MEM: begin
        w_state_n = S_FETCH;
        w_pc_n    = r_pc + 32'd4;
        if (w_opcode == OP_STORE) begin
          w_dmem_we = 4'b1111;
        end else begin
          w_rd_we   = 1'b1;
          w_rd_data = data_mem_if.rdata;
        end
      end
      default: w_state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      if (r_state == S_EXEC) r_instr <= instr_mem_if.rdata;
    end
  end

  assign instr_mem_if.addr = ADDR_WIDTH'(r_pc);
  assign data_mem_if.addr  = w_rs1_val + ((w_opcode == OP_STORE) ? w_imm_s : w_imm_i);
  assign data_mem_if.wdata = w_rs2_val;
  assign data_mem_if.we    = w_dmem_we;

  jedro_1_regfile regfile_inst (
    .i_clk      (clk_i),
    .i_rstn     (rstn_i),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .o_rs1_data (w_rs1_val),
    .o_rs2_data (w_rs2_val),
    .i_we       (w_rd_we),
    .i_rd_addr  (w_rd),
    .i_rd_data  (w_rd_data)
  );

  jedro_1_csr csr_inst (
    .i_clk   (clk_i),
    .i_rstn  (rstn_i),
    .i_we    (w_csr_we),
    .i_wdata (w_csr_wdata),
    .o_rdata (w_csr_rdata)
  );
endmodule

// File: tb/tb_jedro_1_top.sv
// tb/tb_jedro_1_top.sv - directed and random-program bench for jedro_1_top against an ISA-level model
module tb_jedro_1_top;
  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  ram_read_io #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) imem_if ();
  ram_rw_io dmem_if ();

  jedro_1_top #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .instr_mem_if (imem_if),
    .data_mem_if  (dmem_if)
  );

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];
  logic        dmem_clr = 1'b0;
  int checks = 0;
  int errors = 0;
  int st_count = 0;
  logic [31:0] st_addr  = '0;
  logic [31:0] st_wdata = '0;

  logic [31:0] m_x [0:31];
  logic [31:0] m_dmem [0:63];
  logic [31:0] m_csr, m_pc;

  always @(posedge clk) imem_if.rdata <= imem[imem_if.addr[7:2]];

  always @(posedge clk) begin
    dmem_if.rdata <= dmem[dmem_if.addr[7:2]];
    if (dmem_clr) for (int i = 0; i < 64; i++) dmem[i] <= '0;
    else if (dmem_if.we == 4'hF) dmem[dmem_if.addr[7:2]] <= dmem_if.wdata;
  end

  always @(negedge clk) if (dmem_if.we != 4'h0) begin
    st_count = st_count + 1;
    st_addr  = dmem_if.addr;
    st_wdata = dmem_if.wdata;
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] rf(input int i);
    return dut.regfile_inst.regfile[i];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn     = 1'b0;
    dmem_clr = 1'b1;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    @(negedge clk);
    @(negedge clk);
    dmem_clr = 1'b0;
  endtask

  task automatic run(input int cycles);
    @(negedge clk);
    rstn = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  // Instruction-set-level reference: executes the program straight from imem until it reaches the tail loop
  task automatic model_run(input int n);
    logic [31:0] ins, a, b, v, nxt, t, src, ii, is, ib, iu;
    logic [4:0]  rd, rs1, sh;
    logic [2:0]  f3;
    logic        wr, tk;
    int          steps;
    for (int i = 0; i < 32; i++) m_x[i] = '0;
    for (int i = 0; i < 64; i++) m_dmem[i] = '0;
    m_csr = '0;
    m_pc  = '0;
    steps = 0;
    while (m_pc < 32'(4 * n) && steps < 200) begin
      ins = imem[m_pc[7:2]];
      rd  = ins[11:7];
      rs1 = ins[19:15];
      f3  = ins[14:12];
      a   = m_x[rs1];
      ii  = {{20{ins[31]}}, ins[31:20]};
      is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      iu  = {ins[31:12], 12'b0};
      nxt = m_pc + 4;
      wr  = 1'b0;
      v   = '0;
      case (ins[6:0])
        7'h37: begin wr = 1'b1; v = iu; end
        7'h17: begin wr = 1'b1; v = m_pc + iu; end
        7'h63: begin
          b = m_x[ins[24:20]];
          case (f3)
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = ($signed(a) < $signed(b));
            3'd5: tk = ($signed(a) >= $signed(b));
            3'd6: tk = (a < b);
            3'd7: tk = (a >= b);
            default: tk = 1'b0;
          endcase
          if (tk) nxt = m_pc + ib;
        end
        7'h13, 7'h33: begin
          b  = (ins[6:0] == 7'h33) ? m_x[ins[24:20]] : ii;
          sh = b[4:0];
          wr = 1'b1;
          case (f3)
            3'd0: v = (ins[6:0] == 7'h33 && ins[30]) ? a - b : a + b;
            3'd1: v = a << sh;
            3'd2: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: v = (a < b) ? 32'd1 : 32'd0;
            3'd4: v = a ^ b;
            3'd5: v = ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: v = a | b;
            default: v = a & b;
          endcase
        end
        7'h03: if (f3 == 3'd2) begin t = a + ii; wr = 1'b1; v = m_dmem[t[7:2]]; end
        7'h23: if (f3 == 3'd2) begin t = a + is; m_dmem[t[7:2]] = m_x[ins[24:20]]; end
        7'h73: if (ins[31:20] == 12'h340 && f3[1:0] != 2'd0) begin
          src = f3[2] ? {27'b0, rs1} : a;
          wr  = 1'b1;
          v   = m_csr;
          if (f3[1:0] == 2'd1) m_csr = src;
          else if (rs1 != 5'd0) m_csr = (f3[1:0] == 2'd2) ? (m_csr | src) : (m_csr & ~src);
        end
        default: ;
      endcase
      if (wr && rd != 5'd0) m_x[rd] = v;
      m_pc = nxt;
      steps++;
    end
  endtask

  task automatic gen_prog(input int n);
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    int          kind, idx;
    for (int k = 0; k < n; k++) begin
      kind = $urandom_range(0, 8);
      rd   = 5'($urandom_range(0, 7));
      rs1  = 5'($urandom_range(0, 7));
      rs2  = 5'($urandom_range(0, 7));
      f3   = 3'($urandom_range(0, 7));
      imm  = 12'($urandom);
      case (kind)
        0: begin
          if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
          if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, imm[4:0]};
          imem[k] = enc_i(imm, rs1, f3, rd, 7'h13);
        end
        1: imem[k] = enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                           rs2, rs1, f3, rd);
        2: imem[k] = {20'($urandom), rd, 7'h37};
        3: imem[k] = {20'($urandom), rd, 7'h17};
        4: imem[k] = enc_s(12'(4 * $urandom_range(0, 63)), rs2, 5'd0);
        5: imem[k] = enc_i(12'(4 * $urandom_range(0, 63)), 5'd0, 3'b010, rd, 7'h03);
        6: begin
          idx = $urandom_range(0, 5);
          f3  = (idx < 3) ? 3'(idx + 1) : 3'(idx + 2);
          if (f3[2]) rs1 = 5'($urandom_range(0, 31));
          imem[k] = enc_i(($urandom_range(0, 3) == 0) ? 12'h341 : 12'h340, rs1, f3, rd, 7'h73);
        end
        7: begin
          idx = $urandom_range(0, 5);
          f3  = (idx < 2) ? 3'(idx) : 3'(idx + 2);
          imem[k] = enc_b(13'd8, rs2, rs1, f3);
        end
        default: imem[k] = 32'h0000_000F;
      endcase
    end
    imem[n]     = enc_j(21'd0, 5'd0);
    imem[n + 1] = enc_j(21'd0, 5'd0);
  endtask

  initial begin
    int base;

    // Reset-time forced CSR next value, then CSRRWI x1, mscratch, 6
    do_reset();
    imem[0] = enc_i(12'h340, 5'd6, 3'b101, 5'd1, 7'h73);
    imem[1] = enc_j(21'd0, 5'd0);
    @(negedge clk);
    rstn = 1'b1;
    force dut.csr_inst.csr_mscratch_n = 32'd3;
    @(negedge clk);
    release dut.csr_inst.csr_mscratch_n;
    chk("forced_mscratch", dut.csr_inst.csr_mscratch_r, 32'd3);
    repeat (30) @(negedge clk);
    chk("csrrwi_rd_old", rf(1), 32'd3);
    chk("csrrwi_new", dut.csr_inst.csr_mscratch_r, 32'd6);

    // CSRRWI x0 still writes; CSRRS with x0 only reads
    do_reset();
    imem[0] = enc_i(12'h340, 5'd5, 3'b101, 5'd0, 7'h73);
    imem[1] = enc_i(12'h340, 5'd0, 3'b010, 5'd3, 7'h73);
    imem[2] = enc_j(21'd0, 5'd0);
    run(20);
    chk("csrrs_x0_rd", rf(3), 32'd5);
    chk("csrrs_x0_keep", dut.csr_inst.csr_mscratch_r, 32'd5);

    do_reset();
    chk("rst_x3", rf(3), 32'd0);
    chk("rst_mscratch", dut.csr_inst.csr_mscratch_r, 32'd0);
    chk("rst_pc", dut.r_pc, 32'd0);
    chk("rst_iaddr", imem_if.addr, 32'd0);
    chk("rst_we", {28'd0, dmem_if.we}, 32'd0);

    // ADDI chain and write to x0
    imem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13);
    imem[1] = enc_i(12'hFF9, 5'd1, 3'b000, 5'd2, 7'h13);
    imem[2] = enc_i(12'd9, 5'd0, 3'b000, 5'd0, 7'h13);
    imem[3] = enc_j(21'd0, 5'd0);
    run(20);
    chk("addi_x1", rf(1), 32'd5);
    chk("addi_x2", rf(2), 32'hFFFF_FFFE);
    chk("addi_x0", rf(0), 32'd0);

    // Store then load
    do_reset();
    imem[0] = enc_i(12'h055, 5'd0, 3'b000, 5'd1, 7'h13);
    imem[1] = enc_s(12'd8, 5'd1, 5'd0);
    imem[2] = enc_i(12'd8, 5'd0, 3'b010, 5'd2, 7'h03);
    imem[3] = enc_j(21'd0, 5'd0);
    base = st_count;
    run(25);
    chk("sw_cycles", 32'(st_count - base), 32'd1);
    chk("sw_addr", st_addr, 32'd8);
    chk("sw_wdata", st_wdata, 32'h55);
    chk("lw_x2", rf(2), 32'h55);

    // Taken BNE skips one instruction
    do_reset();
    imem[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1, 7'h13);
    imem[1] = enc_b(13'd8, 5'd0, 5'd1, 3'b001);
    imem[2] = enc_i(12'd7, 5'd0, 3'b000, 5'd2, 7'h13);
    imem[3] = enc_i(12'd9, 5'd0, 3'b000, 5'd3, 7'h13);
    imem[4] = enc_j(21'd0, 5'd0);
    run(20);
    chk("bne_skip_x2", rf(2), 32'd0);
    chk("bne_tgt_x3", rf(3), 32'd9);

    // Reset asserted during EXEC of ADDI x1,x0,5
    do_reset();
    imem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13);
    imem[1] = enc_j(21'd0, 5'd0);
    base = st_count;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("abort_x1", rf(1), 32'd0);
    chk("abort_pc", dut.r_pc, 32'd0);
    chk("abort_iaddr", imem_if.addr, 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_x1_hold", rf(1), 32'd0);
    chk("abort_no_store", 32'(st_count - base), 32'd0);
    run(10);
    chk("restart_x1", rf(1), 32'd5);

    // Random straight-line programs against the ISA model
    for (int p = 0; p < 6; p++) begin
      do_reset();
      gen_prog(20);
      model_run(20);
      run(3 * 22 + 10);
      for (int r = 1; r < 8; r++) chk($sformatf("rand%0d_x%0d", p, r), rf(r), m_x[r]);
      chk($sformatf("rand%0d_mscratch", p), dut.csr_inst.csr_mscratch_r, m_csr);
      for (int w = 0; w < 64; w++) chk($sformatf("rand%0d_mem%0d", p, w), dmem[w], m_dmem[w]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
